// File: rtl/sz_pkg.sv
// Shared definitions for the SZ first-stage predictor path.
//   f32_t          : raw IEEE-754 single-precision word (bit-exact, no math)
//   feed_state_e   : history feeder FSM states, also used by bench monitors
//   BLOCK_LEN_DEF  : default samples per block
//   TIMEOUT_DEF    : default reconstruction feedback window in cycles
package sz_pkg;
  localparam int FLOAT_W       = 32;
  localparam int BLOCK_LEN_DEF = 1024;
  localparam int TIMEOUT_DEF   = 64;

  typedef logic [FLOAT_W-1:0] f32_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } feed_state_e;
endpackage

// File: rtl/sz_hist_shift.sv
// Two-entry reconstructed-history register.
//   clk, rst     : clock, synchronous active-low reset
//   shift_i      : push din_i as newest entry (p1 <= p2, p2 <= din)
//   clear_i      : drop all history (block start); wins over shift_i
//   din_i        : reconstructed value to push
//   p1_o / p2_o  : older / newer history entry (0 when not yet filled)
//   cnt_o        : number of valid entries, saturating at 2
module sz_hist_shift #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_i,
  input  logic         clear_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] p1_o,
  output logic [W-1:0] p2_o,
  output logic [1:0]   cnt_o
);
  logic [W-1:0] p1_q, p2_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (!rst || clear_i) begin
      p1_q  <= '0;
      p2_q  <= '0;
      cnt_q <= 2'd0;
    end else if (shift_i) begin
      p1_q  <= p2_q;
      p2_q  <= din_i;
      cnt_q <= (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
    end
  end

  assign p1_o  = p1_q;
  assign p2_o  = p2_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/sz_history_feeder.sv
// Feeds raw samples to the SZ curve-fitting predictor one at a time, each
// paired with the two latest reconstructed values, and stalls until the
// predictor returns the reconstruction so history matches the decompressor.
//   clk, rst                    : clock, synchronous active-low reset
//   in_valid/in_ready/in_data   : raw sample handshake
//   out_valid                   : one-cycle issue strobe
//   proceed1/proceed2           : s[n-2] / s[n-1] reconstructed
//   data_in                     : current raw sample (held until next issue)
//   sample_idx, hist_cnt        : position in block, valid history entries
//   recon_valid/recon_data      : reconstructed s[n] from the predictor
//   timeout_err, proto_err      : sticky error flags
module sz_history_feeder
  import sz_pkg::*;
#(
  parameter int W         = FLOAT_W,
  parameter int BLOCK_LEN = BLOCK_LEN_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  output logic [W-1:0]     proceed1,
  output logic [W-1:0]     proceed2,
  output logic [W-1:0]     data_in,
  output logic [CNT_W-1:0] sample_idx,
  output logic [1:0]       hist_cnt,
  input  logic             recon_valid,
  input  logic [W-1:0]     recon_data,
  output logic             timeout_err,
  output logic             proto_err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  feed_state_e      state_q, state_d;
  logic             rdy_q;
  logic [W-1:0]     data_q;
  logic [CNT_W-1:0] idx_q;
  logic [TW-1:0]    wdog_q;
  logic             to_err_q, pr_err_q;

  logic accept, wdog_hit, done, expire, last;

  assign accept   = (state_q == IDLE) && rdy_q && in_valid;
  // wdog_q counts completed WAIT cycles; this is the TIMEOUT-th one.
  assign wdog_hit = (wdog_q == TW'(TIMEOUT - 1));
  assign done     = (state_q == WAIT) && (recon_valid || wdog_hit);
  // A recon in the expiry cycle wins, so no error is raised then.
  assign expire   = (state_q == WAIT) && wdog_hit && !recon_valid;
  assign last     = (idx_q == CNT_W'(BLOCK_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ISSUE);
    in_ready  = rdy_q;
  end

  // in_ready is registered so it reads 0 throughout reset and rises on the
  // first cycle after release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdy_q    <= 1'b0;
      data_q   <= '0;
      idx_q    <= '0;
      wdog_q   <= '0;
      to_err_q <= 1'b0;
      pr_err_q <= 1'b0;
    end else begin
      rdy_q <= (state_d == IDLE);
      if (accept) data_q <= in_data;
      if (state_q == ISSUE)     wdog_q <= '0;
      else if (state_q == WAIT) wdog_q <= wdog_q + TW'(1);
      if (done) idx_q <= last ? '0 : idx_q + CNT_W'(1);
      if (expire) to_err_q <= 1'b1;
      if (recon_valid && state_q != WAIT) pr_err_q <= 1'b1;
    end
  end

  // On timeout the raw sample stands in for the missing reconstruction.
  sz_hist_shift #(.W(W)) u_hist (
    .clk     (clk),
    .rst     (rst),
    .shift_i (done && !last),
    .clear_i (done && last),
    .din_i   (recon_valid ? recon_data : data_q),
    .p1_o    (proceed1),
    .p2_o    (proceed2),
    .cnt_o   (hist_cnt)
  );

  assign data_in     = data_q;
  assign sample_idx  = idx_q;
  assign timeout_err = to_err_q;
  assign proto_err   = pr_err_q;
endmodule
